// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary wrap pointers, combinational status decodes and
// a choice of registered-read or first-word-fall-through output.
module sync_fifo #(
   parameter int DATA_SIZE  = 8,
   parameter int ADDR_SIZE  = 4,
   parameter int FWFT       = 0,
   parameter int AFULL_LVL  = (1 << ADDR_SIZE) - 2,
   parameter int AEMPTY_LVL = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_SIZE-1:0] w_data,
   input  logic                 w_en,
   input  logic                 r_en,
   output logic [DATA_SIZE-1:0] r_data,
   output logic                 w_full,
   output logic                 w_almost_full,
   output logic                 r_empty,
   output logic                 r_almost_empty,
   output logic [ADDR_SIZE:0]   count,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int DEPTH = 1 << ADDR_SIZE;
   localparam logic [ADDR_SIZE:0] DEPTH_C  = (ADDR_SIZE+1)'(DEPTH);
   localparam logic [ADDR_SIZE:0] AFULL_C  = (ADDR_SIZE+1)'(AFULL_LVL);
   localparam logic [ADDR_SIZE:0] AEMPTY_C = (ADDR_SIZE+1)'(AEMPTY_LVL);
   localparam logic [ADDR_SIZE:0] PTR_ONE  = (ADDR_SIZE+1)'(1);

   logic [DATA_SIZE-1:0] r_mem [DEPTH];
   logic [ADDR_SIZE:0]   r_wptr;
   logic [ADDR_SIZE:0]   r_rptr;
   logic                 r_ovf;
   logic                 r_udf;

   logic [ADDR_SIZE:0]   w_count;
   logic                 w_full_i;
   logic                 w_empty_i;
   logic                 w_wr_acc;
   logic                 w_rd_acc;

   // Handshake: w_en/r_en are requests sampled at the rising edge; a request is
   // taken only when the FIFO can honour it (not full / not empty), otherwise it
   // is dropped and only the matching sticky error flag records it.
   assign w_count   = r_wptr - r_rptr;
   assign w_full_i  = (w_count == DEPTH_C);
   assign w_empty_i = (w_count == '0);
   assign w_wr_acc  = w_en & ~w_full_i;
   assign w_rd_acc  = r_en & ~w_empty_i;

   assign count          = w_count;
   assign w_full         = w_full_i;
   assign r_empty        = w_empty_i;
   assign w_almost_full  = (w_count >= AFULL_C);
   assign r_almost_empty = (w_count <= AEMPTY_C);
   assign overflow       = r_ovf;
   assign underflow      = r_udf;

   // Storage is deliberately left uncleared by reset; pointers alone decide visibility.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_acc) begin
         r_mem[r_wptr[ADDR_SIZE-1:0]] <= w_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_ovf  <= 1'b0;
         r_udf  <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_rd_acc) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
         if (w_en && w_full_i) begin
            r_ovf <= 1'b1;
         end
         if (r_en && w_empty_i) begin
            r_udf <= 1'b1;
         end
      end
   end

   generate
      if (FWFT == 0) begin : g_std
         logic [DATA_SIZE-1:0] r_rdata;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_rdata <= '0;
            end else if (w_rd_acc) begin
               r_rdata <= r_mem[r_rptr[ADDR_SIZE-1:0]];
            end
         end

         assign r_data = r_rdata;
      end else begin : g_fwft
         // Head word shown directly; zero while empty so stale words never leak out.
         assign r_data = w_empty_i ? '0 : r_mem[r_rptr[ADDR_SIZE-1:0]];
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Random and directed checks of sync_fifo in both read modes against a queue model.
module tb_sync_fifo;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk;
   logic          rst;
   logic [DW-1:0] w_data;
   logic          w_en;
   logic          r_en;

   logic [DW-1:0] r_data0, r_data1;
   logic          w_full0, w_full1;
   logic          w_afull0, w_afull1;
   logic          r_empty0, r_empty1;
   logic          r_aempty0, r_aempty1;
   logic [AW:0]   count0, count1;
   logic          ovf0, ovf1;
   logic          udf0, udf1;

   sync_fifo #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .FWFT(0)) dut0 (
      .clk(clk), .rst(rst), .w_data(w_data), .w_en(w_en), .r_en(r_en),
      .r_data(r_data0), .w_full(w_full0), .w_almost_full(w_afull0),
      .r_empty(r_empty0), .r_almost_empty(r_aempty0), .count(count0),
      .overflow(ovf0), .underflow(udf0)
   );

   sync_fifo #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .FWFT(1)) dut1 (
      .clk(clk), .rst(rst), .w_data(w_data), .w_en(w_en), .r_en(r_en),
      .r_data(r_data1), .w_full(w_full1), .w_almost_full(w_afull1),
      .r_empty(r_empty1), .r_almost_empty(r_aempty1), .count(count1),
      .overflow(ovf1), .underflow(udf1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model state
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] m_rd0;
   bit            m_ovf;
   bit            m_udf;
   bit            chk_en;
   int            n_chk;
   int            n_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: apply one cycle of inputs, then advance the model by the same edge
   task automatic cyc(input bit we, input bit re, input logic [DW-1:0] wd, input bit rs);
      bit full;
      bit empty;
      w_en   = we;
      r_en   = re;
      w_data = wd;
      rst    = rs;
      @(posedge clk);
      if (rs) begin
         exp_q.delete();
         m_rd0 = '0;
         m_ovf = 0;
         m_udf = 0;
      end else begin
         full  = (exp_q.size() == DEPTH);
         empty = (exp_q.size() == 0);
         if (we && full)   m_ovf = 1;
         if (re && empty)  m_udf = 1;
         if (re && !empty) m_rd0 = exp_q.pop_front();
         if (we && !full)  exp_q.push_back(wd);
      end
      @(negedge clk);
   endtask

   // scoreboard: every settled cycle, both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         int n;
         n = exp_q.size();
         chk("count0", 32'(count0), 32'(n));
         chk("count1", 32'(count1), 32'(n));
         chk("full0", 32'(w_full0), 32'(n == DEPTH));
         chk("full1", 32'(w_full1), 32'(n == DEPTH));
         chk("empty0", 32'(r_empty0), 32'(n == 0));
         chk("empty1", 32'(r_empty1), 32'(n == 0));
         chk("afull0", 32'(w_afull0), 32'(n >= DEPTH - 2));
         chk("afull1", 32'(w_afull1), 32'(n >= DEPTH - 2));
         chk("aempty0", 32'(r_aempty0), 32'(n <= 2));
         chk("aempty1", 32'(r_aempty1), 32'(n <= 2));
         chk("ovf0", 32'(ovf0), 32'(m_ovf));
         chk("ovf1", 32'(ovf1), 32'(m_ovf));
         chk("udf0", 32'(udf0), 32'(m_udf));
         chk("udf1", 32'(udf1), 32'(m_udf));
         chk("rdata0", 32'(r_data0), 32'(m_rd0));
         if (n > 0) chk("rdata1_head", 32'(r_data1), 32'(exp_q[0]));
         else       chk("rdata1_empty", 32'(r_data1), 32'h0);
      end
   end

   initial begin
      logic [DW-1:0] v;
      n_chk  = 0;
      n_err  = 0;
      chk_en = 0;
      m_rd0  = '0;
      w_en   = 0;
      r_en   = 0;
      w_data = '0;
      rst    = 1;
      cyc(0, 0, 8'h00, 1);
      cyc(0, 0, 8'h00, 1);
      chk_en = 1;
      cyc(0, 0, 8'h00, 0);

      // reset state pinned by hand
      chk("rst_count", 32'(count0), 32'd0);
      chk("rst_empty", 32'(r_empty0), 32'd1);
      chk("rst_aempty", 32'(r_aempty0), 32'd1);
      chk("rst_afull", 32'(w_afull0), 32'd0);
      chk("rst_rdata0", 32'(r_data0), 32'd0);
      chk("rst_rdata1", 32'(r_data1), 32'd0);

      // fill 0x01..0x10, almost-full turns on at 14
      for (int i = 1; i <= DEPTH; i++) begin
         cyc(1, 0, DW'(i), 0);
         if (i == 13) chk("afull_at13", 32'(w_afull0), 32'd0);
         if (i == 14) chk("afull_at14", 32'(w_afull0), 32'd1);
      end
      chk("fill_full", 32'(w_full0), 32'd1);
      chk("fill_count", 32'(count0), 32'd16);

      // drain in order
      for (int i = 1; i <= DEPTH; i++) begin
         cyc(0, 1, 8'h00, 0);
         chk("drain_data", 32'(r_data0), 32'(i));
      end
      chk("drain_empty", 32'(r_empty0), 32'd1);

      // full with simultaneous write+read: read wins, write dropped
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, DW'(8'h80 + i), 0);
      cyc(1, 1, 8'hAA, 0);
      chk("ovf_count", 32'(count0), 32'd15);
      chk("ovf_flag", 32'(ovf0), 32'd1);
      chk("ovf_rdata", 32'(r_data0), 32'h80);
      for (int i = 0; i < 15; i++) cyc(0, 1, 8'h00, 0);
      chk("ovf_last", 32'(r_data0), 32'h8F);
      chk("ovf_sticky", 32'(ovf0), 32'd1);

      // empty with simultaneous write+read: write wins, read dropped
      cyc(1, 1, 8'h55, 0);
      chk("udf_count", 32'(count0), 32'd1);
      chk("udf_flag", 32'(udf0), 32'd1);
      cyc(0, 1, 8'h00, 0);
      chk("udf_read", 32'(r_data0), 32'h55);

      // fall-through visibility
      cyc(0, 0, 8'h00, 1);
      cyc(1, 0, 8'h3C, 0);
      chk("fwft_vis_empty", 32'(r_empty1), 32'd0);
      chk("fwft_vis_data", 32'(r_data1), 32'h3C);
      cyc(1, 0, 8'h3D, 0);
      cyc(0, 1, 8'h00, 0);
      chk("fwft_pop_data", 32'(r_data1), 32'h3D);

      // steady state at 8 over several pointer wraps, then reset mid-stream
      cyc(0, 0, 8'h00, 1);
      for (int i = 0; i < 8; i++) cyc(1, 0, DW'($urandom_range(0, 255)), 0);
      for (int i = 0; i < 40; i++) cyc(1, 1, DW'($urandom_range(0, 255)), 0);
      chk("steady_count", 32'(count0), 32'd8);
      cyc(1, 1, 8'h77, 1);
      chk("midrst_count", 32'(count0), 32'd0);
      chk("midrst_empty", 32'(r_empty1), 32'd1);
      chk("midrst_ovf", 32'(ovf0), 32'd0);

      // random traffic with shifting read/write bias and rare resets
      for (int blk = 0; blk < 10; blk++) begin
         int wp;
         int rp;
         wp = $urandom_range(20, 90);
         rp = $urandom_range(20, 90);
         for (int i = 0; i < 200; i++) begin
            v = DW'($urandom_range(0, 255));
            cyc($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, v,
                $urandom_range(0, 199) == 0);
         end
      end

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
